instr_fetch_queue: RTL and testbench

- Instruction-fetch front end that sits directly upstream of the mini CPU's execute stage.
- Issues in-order read requests for 16-bit instructions to an instruction memory that has variable latency, and buffers the returned words in a small FIFO.
- Hands each instruction, tagged with its PC, to the execute stage over a valid/ready handshake.
- Supports a redirect (jump/flush) that discards every queued and in-flight instruction.

---
 rtl/mini_cpu_pkg.sv | 37 +++
 rtl/fetch_fifo.sv | 57 +++++
 rtl/instr_fetch_queue.sv | 174 +++++++++++++++++
 tb/tb_instr_fetch_queue.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mini_cpu_pkg.sv
// Shared types and constants for the mini CPU: instruction layout, opcodes, default widths.
// Latency: none (declarations only).
// Backpressure: not applicable.
package mini_cpu_pkg;

  // Default datapath widths used by the CPU blocks.
  localparam int DEFAULT_PC_WIDTH    = 4;
  localparam int DEFAULT_INSTR_WIDTH = 16;
  localparam int DEFAULT_REG_WIDTH   = 8;

  // Opcode encodings carried in the top nibble of each instruction.
  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_OR    = 4'b0011;
  localparam logic [3:0] OP_XOR   = 4'b0100;
  localparam logic [3:0] OP_SHL   = 4'b0101;
  localparam logic [3:0] OP_SHR   = 4'b0110;
  localparam logic [3:0] OP_MOV   = 4'b0111;
  localparam logic [3:0] OP_LOAD  = 4'b1000;
  localparam logic [3:0] OP_STORE = 4'b1001;

  // 16-bit instruction word: {opcode, rd, rs1, rs2}.
  typedef struct packed {
    logic [3:0] opcode;
    logic [3:0] rd;
    logic [3:0] rs1;
    logic [3:0] rs2;
  } instr_t;

  // Fetch front-end control states.
  typedef enum logic {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with push, pop, flush, occupancy count and a register-array head.
// Latency: a push at cycle t is visible at the head at t+1 (no bypass).
// Backpressure: pushes while full and pops while empty are ignored; flush overrides both.
module fetch_fifo #(
  parameter int DATA_WIDTH = 20,
  parameter int DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [DATA_WIDTH-1:0]        push_data,
  input  logic                         pop,
  input  logic                         flush,
  output logic [DATA_WIDTH-1:0]        head,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  full;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two; flush empties the queue.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage array; only accepted pushes write, contents need no reset.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

  // The producer is expected to hold its own credit and never push into a full queue.
  assert property (@(posedge clk) disable iff (reset) !(push && full && !flush))
    else $error("fetch_fifo: push while full");

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch front end: in-order requests to variable-latency imem, PC-tagged queue, redirect flush.
// Latency: request to out_valid is 2 cycles minimum with a 1-cycle memory; redirect clears out_valid next cycle.
// Backpressure: requests throttled by queue credit (occupancy + outstanding < FIFO_DEPTH); head held while !out_ready.
// Optional: define FETCH_STALL_CNT_EN to add the stall_cycles starvation counter port.
module instr_fetch_queue
  import mini_cpu_pkg::*;
#(
  parameter int PC_WIDTH    = DEFAULT_PC_WIDTH,
  parameter int INSTR_WIDTH = DEFAULT_INSTR_WIDTH,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic [PC_WIDTH-1:0]    mem_req_addr,
  input  logic                   mem_rsp_valid,
  input  logic [INSTR_WIDTH-1:0] mem_rsp_data,
  input  logic                   redirect_valid,
  input  logic [PC_WIDTH-1:0]    redirect_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INSTR_WIDTH-1:0] out_instr,
`ifdef FETCH_STALL_CNT_EN
  output logic [PC_WIDTH-1:0]    out_pc,
  output logic [15:0]            stall_cycles
`else
  output logic [PC_WIDTH-1:0]    out_pc
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  // Queue entry: returned instruction plus the PC it was fetched from.
  typedef struct packed {
    logic [INSTR_WIDTH-1:0] instr;
    logic [PC_WIDTH-1:0]    pc;
  } fq_entry_t;

  localparam int ENTRY_W = $bits(fq_entry_t);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("instr_fetch_queue: FIFO_DEPTH must be a power of two and at least 2");
  end

  fetch_state_t          state;
  fetch_state_t          state_nxt;
  logic [PC_WIDTH-1:0]   fetch_pc;
  logic [PC_WIDTH-1:0]   fetch_pc_nxt;
  logic [PC_WIDTH-1:0]   rsp_pc;
  logic [PC_WIDTH-1:0]   rsp_pc_nxt;
  logic [CNT_W-1:0]      outstanding;
  logic [CNT_W-1:0]      outstanding_nxt;
  logic [CNT_W-1:0]      discard;
  logic [CNT_W-1:0]      discard_nxt;

  logic                  req_hs;
  logic                  rsp_take;
  logic                  credit_ok;
  logic [CNT_W:0]        credit_sum;

  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_flush;
  logic                  fifo_empty;
  logic [CNT_W-1:0]      fifo_count;
  fq_entry_t             push_entry;
  fq_entry_t             head_entry;

  // Credit counts both queued entries and requests whose data is still on its way.
  assign credit_sum    = {1'b0, fifo_count} + {1'b0, outstanding};
  assign credit_ok     = credit_sum < (CNT_W + 1)'(FIFO_DEPTH);
  assign mem_req_valid = !reset && (state == FETCH) && credit_ok;
  assign mem_req_addr  = fetch_pc;
  assign req_hs        = mem_req_valid && mem_req_ready;
  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp_take      = mem_rsp_valid && (outstanding != '0);

  assign push_entry    = '{instr: mem_rsp_data, pc: rsp_pc};
  assign out_valid     = !reset && !fifo_empty;
  assign out_instr     = out_valid ? head_entry.instr : '0;
  assign out_pc        = out_valid ? head_entry.pc : '0;
  assign fifo_pop      = out_valid && out_ready;

  fetch_fifo #(
    .DATA_WIDTH (ENTRY_W),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .flush     (fifo_flush),
    .head      (head_entry),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Next-state logic: redirect wins over everything, otherwise FETCH keeps responses and DRAIN drops them.
  always_comb begin
    state_nxt       = state;
    fetch_pc_nxt    = fetch_pc;
    rsp_pc_nxt      = rsp_pc;
    discard_nxt     = discard;
    fifo_push       = 1'b0;
    fifo_flush      = 1'b0;
    outstanding_nxt = outstanding + CNT_W'(req_hs) - CNT_W'(rsp_take);

    if (redirect_valid) begin
      // Everything still in flight after this cycle belongs to the old stream.
      fifo_flush   = 1'b1;
      fetch_pc_nxt = redirect_pc;
      rsp_pc_nxt   = redirect_pc;
      discard_nxt  = outstanding_nxt;
      state_nxt    = (outstanding_nxt != '0) ? DRAIN : FETCH;
    end else begin
      case (state)
        FETCH: begin
          if (req_hs) fetch_pc_nxt = fetch_pc + PC_WIDTH'(1);
          if (rsp_take) begin
            fifo_push  = 1'b1;
            rsp_pc_nxt = rsp_pc + PC_WIDTH'(1);
          end
        end
        DRAIN: begin
          if (rsp_take) begin
            discard_nxt = discard - CNT_W'(1);
            if (discard == CNT_W'(1)) state_nxt = FETCH;
          end
        end
      endcase
    end
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FETCH;
      fetch_pc    <= '0;
      rsp_pc      <= '0;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      state       <= state_nxt;
      fetch_pc    <= fetch_pc_nxt;
      rsp_pc      <= rsp_pc_nxt;
      outstanding <= outstanding_nxt;
      discard     <= discard_nxt;
    end
  end

`ifdef FETCH_STALL_CNT_EN
  logic [15:0] stall_cnt;

  // Count FETCH cycles where execute is ready but starved; saturates, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if ((state == FETCH) && out_ready && !out_valid && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign stall_cycles = reset ? 16'd0 : stall_cnt;
`endif

  assert property (@(posedge clk) disable iff (reset) !(mem_rsp_valid && (outstanding == '0)))
    else $error("instr_fetch_queue: memory response with no request outstanding");

  assert property (@(posedge clk) disable iff (reset) (discard <= outstanding))
    else $error("instr_fetch_queue: discard count exceeds outstanding requests");

endmodule

// File: tb/tb_instr_fetch_queue.sv
module tb_instr_fetch_queue;
  import mini_cpu_pkg::*;

  localparam int PCW   = 4;
  localparam int IW    = 16;
  localparam int DEPTH = 4;

  logic           clk;
  logic           reset;
  logic           mem_req_valid;
  logic           mem_req_ready;
  logic [PCW-1:0] mem_req_addr;
  logic           mem_rsp_valid;
  logic [IW-1:0]  mem_rsp_data;
  logic           redirect_valid;
  logic [PCW-1:0] redirect_pc;
  logic           out_valid;
  logic           out_ready;
  logic [IW-1:0]  out_instr;
  logic [PCW-1:0] out_pc;
`ifdef FETCH_STALL_CNT_EN
  logic [15:0]    stall_cycles;
  int             stall_model;
`endif

  instr_fetch_queue #(
    .PC_WIDTH    (PCW),
    .INSTR_WIDTH (IW),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
`ifdef FETCH_STALL_CNT_EN
    .out_pc         (out_pc),
    .stall_cycles   (stall_cycles)
`else
    .out_pc         (out_pc)
`endif
  );

  // Memory request in flight: address, redirect epoch at issue, earliest response cycle.
  typedef struct {
    logic [PCW-1:0] addr;
    int             epoch;
    int             due;
  } pend_t;

  // Instruction the execute stage should receive, in order.
  typedef struct {
    logic [IW-1:0]  instr;
    logic [PCW-1:0] pc;
  } exp_t;

  pend_t          pipe[$];
  exp_t           expq[$];
  logic [IW-1:0]  imem [16];
  logic [PCW-1:0] exp_fetch_pc;
  int             checks;
  int             errors;
  int             cyc;
  int             epoch;
  int             mon_size;
  bit             mon_ovld;

  bit             k_rst;
  bit             k_force;
  logic [PCW-1:0] k_force_pc;
  int             k_rdy, k_ordy, k_redir, k_gap, k_lat_min, k_lat_max;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic knobs(input int rdy, input int ordy, input int redir, input int gap,
                       input int lmin, input int lmax);
    k_rdy = rdy; k_ordy = ordy; k_redir = redir; k_gap = gap;
    k_lat_min = lmin; k_lat_max = lmax;
  endtask

  // One clock cycle: drive at the falling edge, apply memory-side events at +3.
  task automatic step();
    pend_t p;
    exp_t  e;
    bit    stale;
    @(negedge clk);
    reset          = k_rst;
    mem_req_ready  = ($urandom_range(99) < k_rdy);
    out_ready      = ($urandom_range(99) < k_ordy);
    redirect_valid = 1'b0;
    redirect_pc    = PCW'($urandom_range(15));
    mem_rsp_valid  = 1'b0;
    mem_rsp_data   = IW'($urandom);
    if (!k_rst) begin
      if (k_force) begin
        redirect_valid = 1'b1;
        redirect_pc    = k_force_pc;
      end else if ($urandom_range(999) < k_redir) begin
        redirect_valid = 1'b1;
      end
      if (pipe.size() > 0 && pipe[0].due <= cyc && $urandom_range(99) >= k_gap) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = imem[pipe[0].addr];
      end
    end
    #3;
    if (k_rst) begin
      chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
`ifdef FETCH_STALL_CNT_EN
      chk("rst_stall", 32'(stall_cycles), 32'd0);
      stall_model = 0;
`endif
      pipe.delete();
      expq.delete();
      exp_fetch_pc = '0;
      epoch++;
    end else begin
      stale = 1'b0;
      foreach (pipe[i]) if (pipe[i].epoch != epoch) stale = 1'b1;
      chk("req_valid", 32'(mem_req_valid), 32'(!stale && (mon_size + pipe.size() < DEPTH)));
      if (mem_req_valid && mem_req_ready) begin
        chk("req_addr", 32'(mem_req_addr), 32'(exp_fetch_pc));
        p.addr  = exp_fetch_pc;
        p.epoch = epoch;
        p.due   = cyc + int'($urandom_range(k_lat_max, k_lat_min));
        pipe.push_back(p);
        exp_fetch_pc = exp_fetch_pc + 1'b1;
      end
      if (mem_rsp_valid) begin
        p = pipe.pop_front();
        if (!redirect_valid && p.epoch == epoch) begin
          e.instr = imem[p.addr];
          e.pc    = p.addr;
          expq.push_back(e);
        end
      end
`ifdef FETCH_STALL_CNT_EN
      chk("stall_cycles", 32'(stall_cycles), 32'(stall_model));
      if (!stale && out_ready && !mon_ovld && stall_model < 65535) stall_model++;
`endif
      if (redirect_valid) begin
        epoch++;
        exp_fetch_pc = redirect_pc;
        expq.delete();
      end
    end
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset(input int n);
    k_rst = 1'b1;
    run(n);
    k_rst = 1'b0;
  endtask

  task automatic force_redirect(input logic [PCW-1:0] pc);
    k_force    = 1'b1;
    k_force_pc = pc;
    step();
    k_force    = 1'b0;
  endtask

  // Monitor: compares the execute-side output against the expected stream each cycle.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_instr", 32'(out_instr), 32'd0);
        chk("rst_out_pc", 32'(out_pc), 32'd0);
        mon_size = 0;
        mon_ovld = 1'b0;
      end else begin
        mon_size = expq.size();
        mon_ovld = (mon_size != 0);
        chk("out_valid", 32'(out_valid), 32'(mon_ovld));
        if (mon_ovld) begin
          chk("out_instr", 32'(out_instr), 32'(expq[0].instr));
          chk("out_pc", 32'(out_pc), 32'(expq[0].pc));
          if (out_ready) expq.delete(0);
        end
      end
    end
  end

  initial begin
    instr_t w;
    checks = 0; errors = 0; cyc = 0; epoch = 0;
    mon_size = 0; mon_ovld = 1'b0; exp_fetch_pc = '0;
    k_rst = 1'b1; k_force = 1'b0; k_force_pc = '0;
`ifdef FETCH_STALL_CNT_EN
    stall_model = 0;
`endif
    reset = 1'b1; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;

    imem[0] = 16'h6123;
    for (int i = 1; i < 16; i++) begin
      w.opcode = 4'($urandom_range(9));
      w.rd     = 4'($urandom);
      w.rs1    = 4'($urandom);
      w.rs2    = 4'($urandom);
      imem[i]  = w;
    end

    // 1-cycle memory streaming from reset; runs through the F -> 0 wrap.
    knobs(100, 100, 0, 0, 1, 1);
    do_reset(2);
    run(30);
    // Redirect coinciding with an out handshake and a response.
    force_redirect(4'h3);
    run(8);

    // Execute stalled: queue fills to depth, requests stop; then drains in order.
    knobs(100, 0, 0, 0, 1, 1);
    do_reset(2);
    run(12);
    knobs(100, 100, 0, 0, 1, 1);
    run(10);

    // 3-cycle memory, redirect to A with two requests in flight.
    knobs(100, 100, 0, 0, 3, 3);
    do_reset(2);
    run(1);
    force_redirect(4'hA);
    run(15);

    // Redirect to the last address: requests F, 0, ...
    knobs(100, 100, 0, 0, 1, 2);
    force_redirect(4'hF);
    run(12);

    // Randomised traffic with redirects, gaps and variable latency.
    knobs(70, 70, 60, 20, 1, 4);
    run(1500);
    knobs(85, 50, 150, 30, 1, 5);
    run(1000);
    knobs(100, 100, 20, 0, 1, 2);
    run(400);

`ifdef FETCH_STALL_CNT_EN
    // Memory withholds responses for 10 cycles with execute ready.
    knobs(100, 100, 0, 100, 1, 1);
    do_reset(2);
    run(11);
    chk("stall_after_10", 32'(stall_cycles), 32'd10);
    do_reset(1);
    knobs(100, 100, 0, 0, 1, 1);
    run(10);
`endif

    do_reset(1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
